cnt_seq_checker: RTL and testbench

Receive-side checker for the free-running wrap counter stream (0,1,…,2^(W-1), 0,1,… period 2^(W-1)+1). Sits at the consumer end of the count bus. Hunts for and locks onto the sequence, then flags mismatches and counts wraps and errors. Status goes to the debug/CSR block.

---
 rtl/cnt_chk_pkg.sv | 27 ++
 rtl/cnt_chk_sat_ctr.sv | 29 ++
 rtl/cnt_seq_checker.sv | 144 ++++++++++++++
 tb/tb_cnt_seq_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared types and helpers for the wrap-counter sequence checker.
// Helpers work on a fixed maximum width; callers pass the real count width.
package cnt_chk_pkg;

    localparam int unsigned CNT_MAX_W = 32;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } cnt_chk_state_t;

    // Successor in the 0..2^(w-1) wrap sequence; MSB set marks the wrap point.
    function automatic logic [CNT_MAX_W-1:0] cnt_next(input logic [CNT_MAX_W-1:0] v,
                                                      input int unsigned w);
        if (v[w-1])
            return '0;
        else
            return v + CNT_MAX_W'(1);
    endfunction

    function automatic logic cnt_legal(input logic [CNT_MAX_W-1:0] v,
                                       input int unsigned w);
        return v <= (CNT_MAX_W'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/cnt_chk_sat_ctr.sv
// Saturating event counter with synchronous reset and increment enable.
module cnt_chk_sat_ctr #(
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side checker for the free-running wrap counter stream: hunts, locks,
// then flags mismatches and counts wraps and errors while locked.
module cnt_seq_checker #(
    parameter int W          = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CW         = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [W-1:0]  cnt_in,
    input  logic          cnt_vld,
    output logic          locked,
    output logic          err_pulse,
    output logic          wrap_pulse,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] wrap_count,
    output logic [W-1:0]  expected
);

    import cnt_chk_pkg::*;

    localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int RW      = $clog2(RUN_MAX + 1);
    localparam logic [W-1:0] WRAP_VAL = {1'b1, {(W-1){1'b0}}};

    cnt_chk_state_t state_q, state_d;
    logic [W-1:0]   expected_q, expected_d;
    logic [RW-1:0]  good_run_q, good_run_d;
    logic [RW-1:0]  miss_run_q, miss_run_d;
    logic           locked_q, locked_d;
    logic           err_pulse_q, err_pulse_d;
    logic           wrap_pulse_q, wrap_pulse_d;

    logic           s_match;
    logic           s_legal;
    logic [W-1:0]   s_next;
    logic [W-1:0]   e_next;

    always_comb begin
        s_match = (cnt_in == expected_q);
        s_legal = cnt_legal(CNT_MAX_W'(cnt_in), W);
        s_next  = W'(cnt_next(CNT_MAX_W'(cnt_in), W));
        e_next  = W'(cnt_next(CNT_MAX_W'(expected_q), W));
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        good_run_d   = good_run_q;
        miss_run_d   = miss_run_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;

        if (cnt_vld) begin
            case (state_q)
                HUNT: begin
                    if (s_legal) begin
                        expected_d = s_next;
                        good_run_d = RW'(1);
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (s_match) begin
                        good_run_d = good_run_q + RW'(1);
                        expected_d = s_next;
                        if (good_run_q == RW'(LOCK_CNT - 1)) begin
                            state_d    = LOCKED;
                            miss_run_d = '0;
                        end
                    end else if (s_legal) begin
                        expected_d = s_next;
                        good_run_d = RW'(1);
                    end else begin
                        good_run_d = '0;
                        state_d    = HUNT;
                    end
                end
                LOCKED: begin
                    if (s_match) begin
                        miss_run_d   = '0;
                        expected_d   = s_next;
                        wrap_pulse_d = (cnt_in == WRAP_VAL);
                    end else begin
                        // Freewheel on our own prediction rather than the bad sample.
                        err_pulse_d = 1'b1;
                        miss_run_d  = miss_run_q + RW'(1);
                        expected_d  = e_next;
                        if (miss_run_q == RW'(UNLOCK_CNT - 1)) begin
                            good_run_d = '0;
                            state_d    = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= HUNT;
            expected_q   <= '0;
            good_run_q   <= '0;
            miss_run_q   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            good_run_q   <= good_run_d;
            miss_run_q   <= miss_run_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    cnt_chk_sat_ctr #(.CW(CW)) u_err_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (err_pulse_d),
        .count (err_count)
    );

    cnt_chk_sat_ctr #(.CW(CW)) u_wrap_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (wrap_pulse_d),
        .count (wrap_count)
    );

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: default instance plus a CW=4 instance
// driven by the same stimulus to exercise counter saturation.
module tb_cnt_seq_checker;

    logic        CLK;
    logic        RST;
    logic [7:0]  cnt_in;
    logic        cnt_vld;

    logic        locked, err_pulse, wrap_pulse;
    logic [15:0] err_count, wrap_count;
    logic [7:0]  expected;

    logic        locked4, err_pulse4, wrap_pulse4;
    logic [3:0]  err_count4, wrap_count4;
    logic [7:0]  expected4;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    cnt_seq_checker dut (
        .CLK(CLK), .RST(RST), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
        .err_count(err_count), .wrap_count(wrap_count), .expected(expected)
    );

    cnt_seq_checker #(.CW(4)) dut4 (
        .CLK(CLK), .RST(RST), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .locked(locked4), .err_pulse(err_pulse4), .wrap_pulse(wrap_pulse4),
        .err_count(err_count4), .wrap_count(wrap_count4), .expected(expected4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] v, input logic vld);
        cnt_in  = v;
        cnt_vld = vld;
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int unsigned from, input int unsigned to);
        for (int unsigned v = from; v <= to; v++)
            step(8'(v), 1'b1);
    endtask

    function automatic int unsigned nxt(input int unsigned v);
        return (v == 128) ? 0 : v + 1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, {31'd0, locked}, 0);
        check({tag, "_err_pulse"}, {31'd0, err_pulse}, 0);
        check({tag, "_wrap_pulse"}, {31'd0, wrap_pulse}, 0);
        check({tag, "_err_count"}, {16'd0, err_count}, 0);
        check({tag, "_wrap_count"}, {16'd0, wrap_count}, 0);
        check({tag, "_expected"}, {24'd0, expected}, 0);
        check({tag, "_err_count4"}, {28'd0, err_count4}, 0);
    endtask

    initial begin
        int unsigned e;

        RST = 1'b1; cnt_in = '0; cnt_vld = 1'b0;
        step(8'd0, 1'b0);
        step(8'd0, 1'b0);
        check_all_zero("reset");
        RST = 1'b0;

        // Clean stream: lock after sample 3.
        run(0, 2);
        check("clean_not_locked_yet", {31'd0, locked}, 0);
        step(8'd3, 1'b1);
        check("clean_locked", {31'd0, locked}, 1);
        check("clean_expected", {24'd0, expected}, 4);
        run(4, 127);
        check("clean_err_count", {16'd0, err_count}, 0);
        check("clean_no_wrap_yet", {31'd0, wrap_pulse}, 0);
        step(8'd128, 1'b1);
        check("wrap1_pulse", {31'd0, wrap_pulse}, 1);
        check("wrap1_count", {16'd0, wrap_count}, 1);
        check("wrap1_expected", {24'd0, expected}, 0);
        step(8'd0, 1'b1);
        check("wrap1_pulse_drop", {31'd0, wrap_pulse}, 0);
        run(1, 128);
        check("wrap2_pulse", {31'd0, wrap_pulse}, 1);
        check("wrap2_count", {16'd0, wrap_count}, 2);
        check("wrap2_count4", {28'd0, wrap_count4}, 2);

        // Single glitch while locked.
        run(0, 49);
        step(8'd99, 1'b1);
        check("glitch_err_pulse", {31'd0, err_pulse}, 1);
        check("glitch_err_count", {16'd0, err_count}, 1);
        check("glitch_locked", {31'd0, locked}, 1);
        check("glitch_expected", {24'd0, expected}, 51);
        step(8'd51, 1'b1);
        check("glitch_recover_pulse", {31'd0, err_pulse}, 0);
        check("glitch_recover_expected", {24'd0, expected}, 52);
        check("glitch_recover_count", {16'd0, err_count}, 1);

        // Loss of lock: three consecutive mismatches.
        step(8'd7, 1'b1);
        check("loss1_locked", {31'd0, locked}, 1);
        check("loss1_expected", {24'd0, expected}, 53);
        step(8'd7, 1'b1);
        check("loss2_locked", {31'd0, locked}, 1);
        step(8'd7, 1'b1);
        check("loss3_locked", {31'd0, locked}, 0);
        check("loss3_err_pulse", {31'd0, err_pulse}, 1);
        check("loss3_err_count", {16'd0, err_count}, 4);
        check("loss3_expected", {24'd0, expected}, 55);
        run(10, 12);
        check("relock_pending", {31'd0, locked}, 0);
        check("relock_no_err_pulse", {31'd0, err_pulse}, 0);
        step(8'd13, 1'b1);
        check("relock_locked", {31'd0, locked}, 1);
        check("relock_err_count", {16'd0, err_count}, 4);

        // Reset mid-lock with a sample that would otherwise match.
        RST = 1'b1;
        step(8'd14, 1'b1);
        check_all_zero("midreset");
        RST = 1'b0;

        // Illegal value in HUNT.
        step(8'd200, 1'b1);
        check("illegal_hunt_locked", {31'd0, locked}, 0);
        check("illegal_hunt_expected", {24'd0, expected}, 0);

        // vld gaps: 5,_,6,_,7,_,8 locks after four valid samples.
        step(8'd5, 1'b1);
        check("gap_seed_expected", {24'd0, expected}, 6);
        step(8'd99, 1'b0);
        check("gap_hold_expected", {24'd0, expected}, 6);
        step(8'd6, 1'b1);
        step(8'd99, 1'b0);
        step(8'd7, 1'b1);
        step(8'd99, 1'b0);
        check("gap_not_locked_yet", {31'd0, locked}, 0);
        step(8'd8, 1'b1);
        check("gap_locked", {31'd0, locked}, 1);
        check("gap_expected", {24'd0, expected}, 9);
        step(8'd99, 1'b0);
        check("gap_locked_hold", {31'd0, locked}, 1);
        check("gap_locked_no_err", {31'd0, err_pulse}, 0);
        check("gap_locked_err_count", {16'd0, err_count}, 0);
        check("gap_locked_expected", {24'd0, expected}, 9);

        // Saturation: 20 isolated errors, each followed by a match.
        e = 9;
        for (int unsigned i = 0; i < 20; i++) begin
            step((i % 2 == 0) ? 8'd200 : 8'd0, 1'b1);
            check("sat_err_pulse", {31'd0, err_pulse}, 1);
            check("sat_err_pulse4", {31'd0, err_pulse4}, 1);
            check("sat_err_count", {16'd0, err_count}, i + 1);
            check("sat_err_count4", {28'd0, err_count4}, (i + 1 > 15) ? 15 : i + 1);
            e = nxt(e);
            step(8'(e), 1'b1);
            check("sat_match_no_pulse", {31'd0, err_pulse4}, 0);
            check("sat_locked4", {31'd0, locked4}, 1);
            e = nxt(e);
        end
        check("sat_final_count4", {28'd0, err_count4}, 15);
        check("sat_final_expected4", {24'd0, expected4}, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
